// File: rtl/mic1_mem_pkg.sv
// mic1_mem_pkg: shared types for the Mic-1 memory arbiter.
// FSM states, latched request set and big-endian byte select.
package mic1_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_RD_WAIT,
        S_FETCH,
        S_FT_WAIT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        fetch;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] faddr;
    } req_t;

    localparam int LAT_W = 3;

    function automatic logic [7:0] be_byte_sel(
        input logic [31:0] word,
        input logic [1:0]  sel
    );
        logic [7:0] b;
        unique case (sel)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mic1_fetch_buf.sv
// mic1_fetch_buf: one-word instruction buffer (tag, data, valid).
// Filled on RAM fetches, patched by writes to the tagged word.
module mic1_fetch_buf #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [31:0]   fill_data_i,
    input  logic          wr_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic [AW-1:0] look_addr_i,
    output logic          hit_o,
    output logic [31:0]   data_o
);

    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [31:0]   data_q;

    // Buffer registers: fill on fetch, keep coherent with data writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_addr_i;
            data_q  <= fill_data_i;
        end else if (wr_i && valid_q && (wr_addr_i == tag_q)) begin
            data_q  <= wr_data_i;
        end
    end

    assign hit_o  = valid_q && (look_addr_i == tag_q);
    assign data_o = data_q;

endmodule

// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter: serializes Mic-1 data and fetch ports onto one RAM.
// Optional instruction buffer enabled by MIC1_FETCH_BUF_EN.
module mic1_mem_arbiter
    import mic1_mem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              req_fetch,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       rdata,
    output logic              rd_valid,
    output logic [7:0]        instr,
    output logic              fetch_valid,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_LAT - 1);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rword_q, rword_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       instr_q, instr_d;

    logic             accept;
    logic             fb_hit;
    logic [31:0]      fb_data;
    logic             fb_fill;
    logic             fb_wr;
    logic [ADDR_W-1:0] fwaddr;

    assign fwaddr = req_q.faddr[ADDR_W+1:2];

`ifdef MIC1_FETCH_BUF_EN
    mic1_fetch_buf #(
        .AW(ADDR_W)
    ) u_fbuf (
        .clk         (clk),
        .resetn      (resetn),
        .fill_i      (fb_fill),
        .fill_addr_i (fwaddr),
        .fill_data_i (ram_rdata),
        .wr_i        (fb_wr),
        .wr_addr_i   (req_q.daddr[ADDR_W-1:0]),
        .wr_data_i   (req_q.wdata),
        .look_addr_i (fwaddr),
        .hit_o       (fb_hit),
        .data_o      (fb_data)
    );
`else
    logic unused_fb;
    assign fb_hit    = 1'b0;
    assign fb_data   = '0;
    assign unused_fb = fb_fill ^ fb_wr;
`endif

    logic unused_addr;
    assign unused_addr = ^{req_q.daddr, req_q.faddr};

    // Core is stalled except when idle or while the valids pulse.
    assign busy = (state_q != S_IDLE) &&
                  !((state_q == S_DONE) && (req_q.rd || req_q.fetch));

    assign accept = !busy && (req_rd || req_wr || req_fetch);

    assign rd_valid    = (state_q == S_DONE) && req_q.rd;
    assign fetch_valid = (state_q == S_DONE) && req_q.fetch;
    assign rdata       = rdata_q;
    assign instr       = instr_q;

    // Next-state, RAM strobes and result staging.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        rword_d   = rword_q;
        rdata_d   = rdata_q;
        instr_d   = instr_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        fb_fill   = 1'b0;
        fb_wr     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    req_d.rd    = req_rd && !req_wr;
                    req_d.wr    = req_wr;
                    req_d.fetch = req_fetch;
                    req_d.daddr = data_addr;
                    req_d.wdata = data_wdata;
                    req_d.faddr = fetch_addr;
                    state_d = (req_rd || req_wr) ? S_DATA : S_FETCH;
                end else begin
                    req_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                ram_en   = 1'b1;
                ram_we   = req_q.wr;
                ram_addr = req_q.daddr[ADDR_W-1:0];
                if (req_q.wr) begin
                    ram_wdata = req_q.wdata;
                end
                fb_wr = req_q.wr;
                cnt_d = '0;
                if (req_q.wr) begin
                    state_d = req_q.fetch ? S_FETCH : S_DONE;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAT_LAST) begin
                    rword_d = ram_rdata;
                    cnt_d   = '0;
                    state_d = req_q.fetch ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (fb_hit) begin
                    instr_d = be_byte_sel(fb_data, req_q.faddr[1:0]);
                    state_d = S_DONE;
                end else begin
                    ram_en   = 1'b1;
                    ram_addr = fwaddr;
                    cnt_d    = '0;
                    state_d  = S_FT_WAIT;
                end
            end
            S_FT_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAT_LAST) begin
                    instr_d = be_byte_sel(ram_rdata, req_q.faddr[1:0]);
                    fb_fill = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
            end
        endcase

        if ((state_d == S_DONE) && (state_q != S_DONE) && req_q.rd) begin
            rdata_d = rword_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rword_q <= '0;
            rdata_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rword_q <= rword_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// tb_mic1_mem_arbiter: directed checks of the Mic-1 memory arbiter.
// Drives on negedge, samples on negedge, RAM model with latency 1.
module tb_mic1_mem_arbiter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_rd, req_wr, req_fetch;
    logic [31:0]   data_addr, data_wdata, fetch_addr;
    logic [31:0]   rdata;
    logic          rd_valid;
    logic [7:0]    instr;
    logic          fetch_valid, busy, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    logic [31:0]   mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mic1_mem_arbiter #(
        .ADDR_W  (AW),
        .RAM_LAT (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_fetch   (req_fetch),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .fetch_addr  (fetch_addr),
        .rdata       (rdata),
        .rd_valid    (rd_valid),
        .instr       (instr),
        .fetch_valid (fetch_valid),
        .busy        (busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Single-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Drive a one-cycle request; returns in cycle E0+1.
    task automatic issue(input logic rd, input logic wr, input logic fe,
                         input logic [31:0] da, input logic [31:0] wd,
                         input logic [31:0] fa);
        req_rd     = rd;
        req_wr     = wr;
        req_fetch  = fe;
        data_addr  = da;
        data_wdata = wd;
        fetch_addr = fa;
        @(negedge clk);
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        req_fetch  = 1'b0;
    endtask

    task automatic rd_word(input string tag, input logic [31:0] a,
                           input logic [31:0] exp);
        issue(1'b1, 1'b0, 1'b0, a, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, rdata, exp);
        @(negedge clk);
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] fa,
                             input logic [7:0] exp);
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, fa);
        for (int n = 0; n < 8; n++) begin
            if (fetch_valid) break;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
        check({tag, "_byte"}, 32'(instr), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_n, we_n, rv_n;
        resetn     = 1'b0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        req_rd     = 1'b0;
        req_wr     = 1'b0;
        req_fetch  = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        fetch_addr = '0;
        @(negedge clk);
        preload(16'd5, 32'hDEADBEEF);
        preload(16'd2, 32'h0BADF00D);
        preload(16'd3, 32'hA1B2C3D4);
        preload(16'd4, 32'h11223344);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_valids", 32'({rd_valid, fetch_valid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // single read of word 5
        issue(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0);
        check("rd_en", 32'(ram_en), 32'd1);
        check("rd_we", 32'(ram_we), 32'd0);
        check("rd_addr", 32'(ram_addr), 32'd5);
        check("rd_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("rd_en2", 32'(ram_en), 32'd0);
        check("rd_busy2", 32'(busy), 32'd1);
        check("rd_early", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", rdata, 32'hDEADBEEF);
        check("rd_busy3", 32'(busy), 32'd0);
        @(negedge clk);
        check("rd_pulse", 32'(rd_valid), 32'd0);
        check("rd_hold", rdata, 32'hDEADBEEF);

        // single write of word 7
        issue(1'b0, 1'b1, 1'b0, 32'd7, 32'h12345678, 32'd0);
        check("wr_en", 32'(ram_en), 32'd1);
        check("wr_we", 32'(ram_we), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'd7);
        check("wr_wdata", ram_wdata, 32'h12345678);
        check("wr_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("wr_we2", 32'({ram_en, ram_we}), 32'd0);
        check("wr_busy2", 32'(busy), 32'd1);
        check("wr_novalid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("wr_busy3", 32'(busy), 32'd0);
        rd_word("wr_rb", 32'd7, 32'h12345678);

        // read of word 2 plus fetch of byte 0x0D
        issue(1'b1, 1'b0, 1'b1, 32'd2, 32'd0, 32'h0000000D);
        check("rf_en1", 32'(ram_en), 32'd1);
        check("rf_addr1", 32'(ram_addr), 32'd2);
        @(negedge clk);
        check("rf_en2", 32'(ram_en), 32'd0);
        @(negedge clk);
        check("rf_en3", 32'(ram_en), 32'd1);
        check("rf_addr3", 32'(ram_addr), 32'd3);
        check("rf_we3", 32'(ram_we), 32'd0);
        check("rf_noval3", 32'(rd_valid), 32'd0);
        check("rf_hold3", rdata, 32'h12345678);
        @(negedge clk);
        check("rf_busy4", 32'(busy), 32'd1);
        @(negedge clk);
        check("rf_valids", 32'({rd_valid, fetch_valid}), 32'd3);
        check("rf_rdata", rdata, 32'h0BADF00D);
        check("rf_instr", 32'(instr), 32'h000000B2);
        check("rf_busy5", 32'(busy), 32'd0);
        @(negedge clk);
        check("rf_pulse", 32'({rd_valid, fetch_valid}), 32'd0);
        check("rf_ihold", 32'(instr), 32'h000000B2);

        // byte-select extremes
        fetch_chk("fb0", 32'h0000000C, 8'hA1);
        fetch_chk("fb3", 32'h0000000F, 8'hD4);

        // read and write together: only the write happens
        en_n = 0;
        we_n = 0;
        rv_n = 0;
        issue(1'b1, 1'b1, 1'b0, 32'd9, 32'hCAFEF00D, 32'd0);
        for (int i = 0; i < 6; i++) begin
            en_n += int'(ram_en);
            we_n += int'(ram_we);
            rv_n += int'(rd_valid);
            @(negedge clk);
        end
        check("rw_en_cnt", 32'(en_n), 32'd1);
        check("rw_we_cnt", 32'(we_n), 32'd1);
        check("rw_rv_cnt", 32'(rv_n), 32'd0);
        rd_word("rw_rb", 32'd9, 32'hCAFEF00D);

        // reset during the fetch wait
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h00000020);
        check("rst_fen", 32'(ram_en), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("mr_en", 32'(ram_en), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valids", 32'({rd_valid, fetch_valid}), 32'd0);
        check("mr_rdata", rdata, 32'd0);
        check("mr_instr", 32'(instr), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("mr_after", 32'({fetch_valid, busy}), 32'd0);
        rd_word("mr_rd", 32'd5, 32'hDEADBEEF);

`ifdef MIC1_FETCH_BUF_EN
        // buffer miss then hit on word 4
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h00000010);
        check("bm_en", 32'(ram_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("bm_valid", 32'(fetch_valid), 32'd1);
        check("bm_byte", 32'(instr), 32'h00000011);
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h00000011);
        check("bh_en", 32'(ram_en), 32'd0);
        check("bh_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("bh_valid", 32'(fetch_valid), 32'd1);
        check("bh_byte", 32'(instr), 32'h00000022);
        check("bh_busy2", 32'(busy), 32'd0);
        @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 32'd4, 32'h55667788, 32'd0);
        @(negedge clk);
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'h00000012);
        check("bw_en", 32'(ram_en), 32'd0);
        @(negedge clk);
        check("bw_valid", 32'(fetch_valid), 32'd1);
        check("bw_byte", 32'(instr), 32'h00000077);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic1_mem_arbiter.md
# mic1_mem_arbiter

Arbiter and sequencer placing the Mic-1 core's two memory ports, the data port (rd/wr on MAR/MDR) and the instruction port (fetch on PC/MBR), onto one single-port synchronous 32-bit RAM. Concurrent requests are serialized, and the core is held via `busy` until every issued access has completed. The block sits between the `mic1` core's `mem_*` signals and the main memory macro. It also performs big-endian byte extraction for instruction fetches.

## Interface
Parameters:
- `ADDR_W`, 16: RAM word-address width; upper request address bits are ignored.
- `RAM_LAT`, 1: RAM read latency in cycles (1..4), measured from the cycle `ram_en` is high to the cycle `ram_rdata` is valid.

Ports:
- `clk`  in  1  clock; all logic is on posedge.
- `resetn`  in  1  reset: synchronous, active-low.
- `req_rd`  in  1  data read request (one-cycle pulse).
- `req_wr`  in  1  data write request (one-cycle pulse).
- `req_fetch`  in  1  instruction byte fetch request (one-cycle pulse).
- `data_addr`  in  32  data word address.
- `data_wdata`  in  32  write data.
- `fetch_addr`  in  32  instruction byte address.
- `rdata`  out  32  read result, valid while `rd_valid` is high.
- `rd_valid`  out  1  one-cycle pulse signalling read completion.
- `instr`  out  8  fetched byte, valid while `fetch_valid` is high.
- `fetch_valid`  out  1  one-cycle pulse signalling fetch completion.
- `busy`  out  1  stall to the core; requests are ignored while this is high.
- `ram_en`, `ram_we`  out  1  RAM strobes.
- `ram_addr`  out  ADDR_W  RAM word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data.

## Operation
- Requests are sampled only at an edge where `busy`=0. The block latches the addresses, the write data and the request set.
- Service order within one request set: write or read first, then fetch.
- `req_rd` and `req_wr` in the same cycle: the write is served and the read is dropped. No `rd_valid` is produced for the dropped read.
- FSM states:
  - IDLE: any request present goes to DATA if rd/wr is set, else to FETCH.
  - DATA: drives `ram_en`=1 for exactly one cycle, with `ram_we` = write. A read then waits RAM_LAT cycles and captures `ram_rdata`. A write completes immediately. Next state is FETCH if a fetch is pending, else DONE.
  - FETCH: drives `ram_en` for one cycle with `ram_addr` = `fetch_addr[ADDR_W+1:2]`. It then waits RAM_LAT cycles, captures the word and selects the byte, then goes to DONE.
  - DONE: pulses the valids of the completed accesses and returns to IDLE.
- Byte select is big-endian: `fetch_addr[1:0]`=0 selects bits 31:24, and 3 selects bits 7:0.
- Data address mapping: `ram_addr` = `data_addr[ADDR_W-1:0]`.
- Reset, including mid-access: state returns to IDLE, the pending set is dropped, all outputs go to 0, and `ram_en` is deasserted at the next edge.

## Timing
- Request sampled at edge E0.
- `busy` is high from the cycle after E0 through the cycle before the valids. It is low in the cycle the valids are high, so the core may issue again at that edge.
- Single read: `ram_en` is high in cycle E0+1. `rd_valid` is high in cycle E0+2+RAM_LAT.
- Single write: `ram_en` and `ram_we` are high in E0+1. `busy` is high in E0+1 and E0+2.
- Read plus fetch: the fetch's `ram_en` is high in E0+2+RAM_LAT. Both `rd_valid` and `fetch_valid` pulse together in E0+3+2·RAM_LAT.
- The valid pulses last exactly one cycle. `rdata` and `instr` hold their values until the next valid pulse.
- Reset values: `rdata`=0, `instr`=0, all strobes and valids 0, `busy`=0.

## Configuration
- `MIC1_FETCH_BUF_EN` defined:
  - The block keeps a one-word instruction buffer (tag plus valid bit).
  - A fetch whose word address equals the tag, with the valid bit set, is a hit. A hit makes no RAM access, and FETCH is skipped.
  - A fetch-only hit gives `fetch_valid` in E0+2, with `busy` high for E0+1 only.
  - A write to the tagged word updates the buffer with `data_wdata`.
  - Reset clears the valid bit.
- `MIC1_FETCH_BUF_EN` undefined: no buffer exists, and every fetch accesses RAM.

## Structure
- Package `mic1_mem_pkg` holds:
  - the FSM state enum;
  - a request-set struct with fields rd, wr, fetch and the latched addresses/data;
  - function `be_byte_sel(word, sel)`.
- Sub-module `mic1_fetch_buf` holds the tag/data/valid registers and the hit compare. It is instantiated only under the macro.

## Test plan
- `req_rd`, `data_addr`=5, RAM[5]=0xDEADBEEF, RAM_LAT=1 -> `ram_en` high in E0+1; `rd_valid` high in E0+3 with `rdata`=0xDEADBEEF.
- `req_wr`, `data_addr`=7, `data_wdata`=0x12345678 -> a single cycle of `ram_we` with `ram_addr`=7; a subsequent read of 7 returns 0x12345678.
- `req_rd` (addr 2) with `req_fetch` (addr 0x0D) in the same cycle, RAM[3]=0xA1B2C3D4 -> read is issued first; `instr`=0xB2 and `rd_valid` plus `fetch_valid` pulse together in E0+5.
- `req_rd` and `req_wr` together -> only the write reaches RAM; `rd_valid` never pulses.
- `resetn`=0 asserted during the FETCH wait -> next cycle has `ram_en`=0, `busy`=0, no valid pulse; a new read after reset completes normally.
- With `MIC1_FETCH_BUF_EN`: fetch 0x10 then fetch 0x11 -> the second fetch makes no `ram_en` and gives `fetch_valid` in E0+2. A write to word 4 followed by fetch 0x12 returns the new byte.
